// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state type, default timeout and the access legality check.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int unsigned TIMEOUT_DEFAULT = 32'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Encoding is legal for the direction and the address is naturally aligned.
  function automatic logic access_ok(input logic is_store, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      LB:      ok = 1'b1;
      LH:      ok = ~addr_lo[0];
      LW:      ok = (addr_lo == 2'b00);
      LBU:     ok = ~is_store;
      LHU:     ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and lane extraction with
// sign/zero extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [2:0]  st_type,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_rdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_word
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store enables and lane-replicated write data.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0000_0000;
    case (st_type)
      SB: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SH: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      SW: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Byte and halfword lane selection from the read word.
  always_comb begin
    ld_byte_s = 8'h00;
    ld_half_s = 16'h0000;
    case (ld_addr_lo)
      2'b00:   ld_byte_s = ld_rdata[7:0];
      2'b01:   ld_byte_s = ld_rdata[15:8];
      2'b10:   ld_byte_s = ld_rdata[23:16];
      default: ld_byte_s = ld_rdata[31:24];
    endcase
    if (ld_addr_lo[1]) begin
      ld_half_s = ld_rdata[31:16];
    end else begin
      ld_half_s = ld_rdata[15:0];
    end
  end

  // Extension to a full register word.
  always_comb begin
    ld_word = 32'h0000_0000;
    case (ld_type)
      LB:      ld_word = {{24{ld_byte_s[7]}}, ld_byte_s};
      LH:      ld_word = {{16{ld_half_s[15]}}, ld_half_s};
      LW:      ld_word = ld_rdata;
      LBU:     ld_word = {24'h000000, ld_byte_s};
      LHU:     ld_word = {16'h0000, ld_half_s};
      default: ld_word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: sequences one data-memory request/ack
// transaction per access and stalls the upstream pipeline until it completes.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] rs2_data_ex_mem,
  input  logic        memread_ex_mem,
  input  logic        memwrite_ex_mem,
  input  logic [2:0]  loadtype_ex_mem,
  input  logic [2:0]  strtype_ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic [31:0] load_data_mem,
  output logic        load_valid_mem,
  output logic        fault_mem
);

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 32'd1);

  lsu_state_t  state_r;
  logic [15:0] wait_cnt_r;
  logic        is_read_r;
  logic        to_fault_r;
  logic [2:0]  ld_type_r;
  logic [1:0]  addr_lo_r;
  logic        access_s;
  logic        legal_s;
  logic        idle_fault_s;
  logic        timeout_hit_s;
  logic [2:0]  funct3_s;
  logic [3:0]  st_be_s;
  logic [31:0] st_wdata_s;
  logic [31:0] ld_word_s;

  assign access_s      = memread_ex_mem ^ memwrite_ex_mem;
  assign funct3_s      = memwrite_ex_mem ? strtype_ex_mem : loadtype_ex_mem;
  assign legal_s       = access_s & access_ok(memwrite_ex_mem, funct3_s, alu_result_mem[1:0]);
  assign idle_fault_s  = (memread_ex_mem & memwrite_ex_mem) | (access_s & ~legal_s);
  assign timeout_hit_s = (wait_cnt_r == LAST_WAIT);

  // Stall is released in DONE so the pipeline advances exactly once per access.
  assign stall_mem      = ((state_r == IDLE) & legal_s) | (state_r == BUSY);
  assign fault_mem      = ((state_r == IDLE) & idle_fault_s) | ((state_r == DONE) & to_fault_r);
  assign load_valid_mem = (state_r == DONE) & is_read_r & ~to_fault_r;

  lsu_align u_align (
    .st_addr_lo (alu_result_mem[1:0]),
    .st_type    (strtype_ex_mem),
    .st_data    (rs2_data_ex_mem),
    .ld_addr_lo (addr_lo_r),
    .ld_type    (ld_type_r),
    .ld_rdata   (dmem_rdata),
    .st_be      (st_be_s),
    .st_wdata   (st_wdata_s),
    .ld_word    (ld_word_s)
  );

  // Access sequencing, request registers, wait counter and load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      wait_cnt_r    <= 16'd0;
      is_read_r     <= 1'b0;
      to_fault_r    <= 1'b0;
      ld_type_r     <= 3'b000;
      addr_lo_r     <= 2'b00;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0000_0000;
      dmem_be       <= 4'b0000;
      dmem_wdata    <= 32'h0000_0000;
      load_data_mem <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (legal_s) begin
            state_r    <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= memwrite_ex_mem;
            dmem_addr  <= {alu_result_mem[31:2], 2'b00};
            dmem_be    <= memwrite_ex_mem ? st_be_s : 4'b1111;
            dmem_wdata <= memwrite_ex_mem ? st_wdata_s : 32'h0000_0000;
            wait_cnt_r <= 16'd0;
            is_read_r  <= memread_ex_mem;
            ld_type_r  <= loadtype_ex_mem;
            addr_lo_r  <= alu_result_mem[1:0];
            to_fault_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // An ack arriving on the timeout cycle still completes the access.
          if (dmem_ack) begin
            state_r  <= DONE;
            dmem_req <= 1'b0;
            if (is_read_r) begin
              load_data_mem <= ld_word_s;
            end
          end else if (timeout_hit_s) begin
            state_r       <= DONE;
            dmem_req      <= 1'b0;
            to_fault_r    <= 1'b1;
            load_data_mem <= 32'h0000_0000;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        DONE: begin
          state_r    <= IDLE;
          to_fault_r <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu with a behavioural data memory that
// acks after a chosen number of wait cycles.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] alu_result_mem;
  logic [31:0] rs2_data_ex_mem;
  logic        memread_ex_mem;
  logic        memwrite_ex_mem;
  logic [2:0]  loadtype_ex_mem;
  logic [2:0]  strtype_ex_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall_mem;
  logic [31:0] load_data_mem;
  logic        load_valid_mem;
  logic        fault_mem;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ld;
    int          lv;
    logic        fault;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t sb_q[$];
  int   tests;
  int   fails;

  int          o_stalls;
  int          o_reqs;
  int          o_lv;
  logic        o_fault;
  logic        o_unstable;
  logic        o_done;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic        o_we;
  logic [31:0] o_wdata;
  logic [31:0] o_ld;

  mem_stage_lsu #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_result_mem  (alu_result_mem),
    .rs2_data_ex_mem (rs2_data_ex_mem),
    .memread_ex_mem  (memread_ex_mem),
    .memwrite_ex_mem (memwrite_ex_mem),
    .loadtype_ex_mem (loadtype_ex_mem),
    .strtype_ex_mem  (strtype_ex_mem),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .stall_mem       (stall_mem),
    .load_data_mem   (load_data_mem),
    .load_valid_mem  (load_valid_mem),
    .fault_mem       (fault_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one access in IDLE, plays the memory with `waits` wait cycles
  // (negative = never ack) and records what the DUT did until DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] typ,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdata, input int waits);
    int busy_n;
    @(posedge clk);
    #2;
    o_stalls = 0; o_reqs = 0; o_lv = 0; o_fault = 1'b0; o_unstable = 1'b0; o_done = 1'b0;
    o_addr = 32'h0; o_be = 4'h0; o_we = 1'b0; o_wdata = 32'h0; o_ld = 32'h0;
    busy_n = 0;
    memread_ex_mem = rd; memwrite_ex_mem = wr;
    loadtype_ex_mem = typ; strtype_ex_mem = typ;
    alu_result_mem = addr; rs2_data_ex_mem = data; dmem_ack = 1'b0;
    #1;
    if (stall_mem) o_stalls++;
    if (fault_mem) o_fault = 1'b1;
    for (int c = 0; c < 50 && !o_done; c++) begin
      @(posedge clk);
      #2;
      if (dmem_req) begin
        if (o_reqs == 0) begin
          o_addr = dmem_addr; o_be = dmem_be; o_we = dmem_we; o_wdata = dmem_wdata;
        end else if ({dmem_addr, dmem_be, dmem_we, dmem_wdata} !== {o_addr, o_be, o_we, o_wdata}) begin
          o_unstable = 1'b1;
        end
        o_reqs++;
        if (stall_mem) o_stalls++;
        dmem_ack   = (busy_n == waits);
        dmem_rdata = dmem_ack ? rdata : $urandom;
        busy_n++;
      end else begin
        dmem_ack = 1'b0;
        if (stall_mem) o_stalls++;
        if (load_valid_mem) o_lv++;
        if (fault_mem) o_fault = 1'b1;
        o_ld = load_data_mem;
        o_done = 1'b1;
        memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0;
      end
    end
    memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alu_result_mem = 32'h0; rs2_data_ex_mem = 32'h0;
    memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0;
    loadtype_ex_mem = 3'b000; strtype_ex_mem = 3'b000;
    dmem_rdata = 32'h0; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data_mem,
         load_valid_mem, fault_mem, stall_mem} !== 104'h0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wdata=%h ld=%h lv=%b fault=%b stall=%b, want all 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data_mem,
               load_valid_mem, fault_mem, stall_mem);
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #2 dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #2 dmem_ack = 1'b0;
    tests++;
    if ({dmem_req, load_valid_mem, stall_mem, load_data_mem} !== 35'h0) begin
      fails++;
      $display("FAIL idle_ack_ignored: req=%b lv=%b stall=%b ld=%h, want 0 0 0 00000000",
               dmem_req, load_valid_mem, stall_mem, load_data_mem);
    end
  endtask

  task automatic test_stores();
    logic [2:0]  typ   [4];
    logic [31:0] addr  [4];
    logic [31:0] data  [4];
    int          waits [4];
    logic [3:0]  be    [4];
    logic [31:0] wd    [4];
    exp_t e;
    typ  = '{SW, SB, SH, SB};
    addr = '{32'h0000_0104, 32'h0000_0203, 32'h0000_0206, 32'h0000_0100};
    data = '{32'hDEAD_BEEF, 32'h0000_00A5, 32'h1234_BEEF, 32'hCAFE_0011};
    waits = '{0, 1, 0, 0};
    be   = '{4'b1111, 4'b1000, 4'b1100, 4'b0001};
    wd   = '{32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h1111_1111};
    for (int i = 0; i < 4; i++) begin
      e.addr = {addr[i][31:2], 2'b00}; e.be = be[i]; e.we = 1'b1; e.wdata = wd[i];
      e.ld = 32'h0; e.lv = 0; e.fault = 1'b0; e.stalls = 2 + waits[i]; e.reqs = 1 + waits[i];
      sb_q.push_back(e);
      run_access(1'b0, 1'b1, typ[i], addr[i], data[i], 32'h0, waits[i]);
      e = sb_q.pop_front();
      tests++;
      if ({o_addr, o_be, o_we, o_wdata} !== {e.addr, e.be, e.we, e.wdata}) begin
        fails++;
        $display("FAIL store_req[%0d]: got addr=%h be=%b we=%b wdata=%h, want addr=%h be=%b we=%b wdata=%h",
                 i, o_addr, o_be, o_we, o_wdata, e.addr, e.be, e.we, e.wdata);
      end
      tests++;
      if (o_stalls !== e.stalls || o_reqs !== e.reqs || !o_done) begin
        fails++;
        $display("FAIL store_timing[%0d]: got stalls=%0d reqs=%0d done=%b, want stalls=%0d reqs=%0d done=1",
                 i, o_stalls, o_reqs, o_done, e.stalls, e.reqs);
      end
      tests++;
      if (o_lv !== e.lv || o_fault !== e.fault || o_unstable !== 1'b0) begin
        fails++;
        $display("FAIL store_status[%0d]: got lv=%0d fault=%b unstable=%b, want lv=%0d fault=%b unstable=0",
                 i, o_lv, o_fault, o_unstable, e.lv, e.fault);
      end
    end
  endtask

  task automatic test_loads();
    logic [2:0]  typ   [7];
    logic [31:0] addr  [7];
    logic [31:0] rdat  [7];
    int          waits [7];
    logic [31:0] ld    [7];
    exp_t e;
    typ   = '{LB, LBU, LH, LHU, LW, LB, LW};
    addr  = '{32'h0000_0301, 32'h0000_0301, 32'h0000_0302, 32'h0000_0302,
              32'h0000_0400, 32'h0000_0300, 32'h0000_0700};
    rdat  = '{32'h1234_80FF, 32'h1234_80FF, 32'h8001_1234, 32'h8001_1234,
              32'h89AB_CDEF, 32'h1234_807F, 32'h0BAD_F00D};
    waits = '{2, 2, 0, 0, 1, 0, 3};
    ld    = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
              32'h89AB_CDEF, 32'h0000_007F, 32'h0BAD_F00D};
    for (int i = 0; i < 7; i++) begin
      e.addr = {addr[i][31:2], 2'b00}; e.be = 4'b1111; e.we = 1'b0; e.wdata = 32'h0;
      e.ld = ld[i]; e.lv = 1; e.fault = 1'b0; e.stalls = 2 + waits[i]; e.reqs = 1 + waits[i];
      sb_q.push_back(e);
      run_access(1'b1, 1'b0, typ[i], addr[i], $urandom, rdat[i], waits[i]);
      e = sb_q.pop_front();
      tests++;
      if (o_ld !== e.ld || o_lv !== e.lv || o_fault !== e.fault) begin
        fails++;
        $display("FAIL load_data[%0d]: got ld=%h lv=%0d fault=%b, want ld=%h lv=%0d fault=%b",
                 i, o_ld, o_lv, o_fault, e.ld, e.lv, e.fault);
      end
      tests++;
      if ({o_addr, o_be, o_we} !== {e.addr, e.be, e.we} || o_unstable !== 1'b0) begin
        fails++;
        $display("FAIL load_req[%0d]: got addr=%h be=%b we=%b unstable=%b, want addr=%h be=%b we=%b unstable=0",
                 i, o_addr, o_be, o_we, o_unstable, e.addr, e.be, e.we);
      end
      tests++;
      if (o_stalls !== e.stalls || o_reqs !== e.reqs || !o_done) begin
        fails++;
        $display("FAIL load_timing[%0d]: got stalls=%0d reqs=%0d done=%b, want stalls=%0d reqs=%0d done=1",
                 i, o_stalls, o_reqs, o_done, e.stalls, e.reqs);
      end
    end
    @(posedge clk);
    #2;
    tests++;
    if (load_data_mem !== 32'h0BAD_F00D || load_valid_mem !== 1'b0) begin
      fails++;
      $display("FAIL load_hold: got ld=%h lv=%b, want ld=0badf00d lv=0", load_data_mem, load_valid_mem);
    end
  endtask

  task automatic test_access_faults();
    logic        rd   [7];
    logic        wr   [7];
    logic [2:0]  typ  [7];
    logic [31:0] addr [7];
    logic        req_seen;
    rd   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    wr   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    typ  = '{LW, SW, SH, LHU, 3'b011, 3'b100, SB};
    addr = '{32'h0000_0402, 32'h0000_0101, 32'h0000_0501, 32'h0000_0103,
             32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #2;
      memread_ex_mem = rd[i]; memwrite_ex_mem = wr[i];
      loadtype_ex_mem = typ[i]; strtype_ex_mem = typ[i]; alu_result_mem = addr[i];
      #1;
      tests++;
      if (fault_mem !== 1'b1 || stall_mem !== 1'b0) begin
        fails++;
        $display("FAIL idle_fault[%0d]: got fault=%b stall=%b, want fault=1 stall=0", i, fault_mem, stall_mem);
      end
      req_seen = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #2;
        if (dmem_req !== 1'b0) req_seen = 1'b1;
      end
      tests++;
      if (req_seen !== 1'b0) begin
        fails++;
        $display("FAIL idle_fault_noreq[%0d]: got req_seen=%b, want 0", i, req_seen);
      end
      memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    e.addr = 32'h0000_0500; e.be = 4'b1111; e.we = 1'b0; e.wdata = 32'h0;
    e.ld = 32'h0; e.lv = 0; e.fault = 1'b1; e.stalls = 5; e.reqs = 4;
    sb_q.push_back(e);
    run_access(1'b1, 1'b0, LH, 32'h0000_0500, 32'h0, 32'h0, -1);
    e = sb_q.pop_front();
    tests++;
    if (o_reqs !== e.reqs || o_stalls !== e.stalls || !o_done) begin
      fails++;
      $display("FAIL timeout_len: got reqs=%0d stalls=%0d done=%b, want reqs=%0d stalls=%0d done=1",
               o_reqs, o_stalls, o_done, e.reqs, e.stalls);
    end
    tests++;
    if (o_fault !== e.fault || o_lv !== e.lv || o_ld !== e.ld) begin
      fails++;
      $display("FAIL timeout_status: got fault=%b lv=%0d ld=%h, want fault=%b lv=%0d ld=%h",
               o_fault, o_lv, o_ld, e.fault, e.lv, e.ld);
    end
  endtask

  task automatic test_back_to_back();
    logic        rd   [3];
    logic [2:0]  typ  [3];
    logic [31:0] addr [3];
    logic [31:0] ld   [3];
    exp_t e;
    rd   = '{1'b0, 1'b1, 1'b1};
    typ  = '{SW, LW, LB};
    addr = '{32'h0000_0800, 32'h0000_0800, 32'h0000_0803};
    ld   = '{32'h0, 32'h0102_0384, 32'h0000_0001};
    for (int i = 0; i < 3; i++) begin
      e.addr = 32'h0000_0800; e.be = 4'b1111; e.we = ~rd[i];
      e.wdata = rd[i] ? 32'h0 : 32'h0102_0384;
      e.ld = ld[i]; e.lv = rd[i] ? 1 : 0; e.fault = 1'b0; e.stalls = 2; e.reqs = 1;
      sb_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      run_access(rd[i], ~rd[i], typ[i], addr[i], 32'h0102_0384, 32'h0102_0384, 0);
      e = sb_q.pop_front();
      tests++;
      if ({o_addr, o_be, o_we, o_wdata} !== {e.addr, e.be, e.we, e.wdata} ||
          o_stalls !== e.stalls || o_lv !== e.lv || (rd[i] && o_ld !== e.ld)) begin
        fails++;
        $display("FAIL b2b[%0d]: got addr=%h be=%b we=%b wdata=%h stalls=%0d lv=%0d ld=%h, want addr=%h be=%b we=%b wdata=%h stalls=%0d lv=%0d ld=%h",
                 i, o_addr, o_be, o_we, o_wdata, o_stalls, o_lv, o_ld,
                 e.addr, e.be, e.we, e.wdata, e.stalls, e.lv, e.ld);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk);
    #2;
    memread_ex_mem = 1'b1; loadtype_ex_mem = LW; alu_result_mem = 32'h0000_0600;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    tests++;
    if (dmem_req !== 1'b1 || stall_mem !== 1'b1) begin
      fails++;
      $display("FAIL busy_before_reset: got req=%b stall=%b, want 1 1", dmem_req, stall_mem);
    end
    #1 rst = 1'b0; memread_ex_mem = 1'b0;
    #1;
    tests++;
    if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_drop: got req=%b stall=%b, want 0 0", dmem_req, stall_mem);
    end
    #3 rst = 1'b1;
    @(posedge clk);
    #2 dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    @(posedge clk);
    #2 dmem_ack = 1'b0;
    tests++;
    if (dmem_req !== 1'b0 || load_valid_mem !== 1'b0 || load_data_mem !== 32'h0) begin
      fails++;
      $display("FAIL late_ack_ignored: got req=%b lv=%b ld=%h, want 0 0 00000000",
               dmem_req, load_valid_mem, load_data_mem);
    end
    run_access(1'b1, 1'b0, LW, 32'h0000_0604, 32'h0, 32'h55AA_33CC, 0);
    tests++;
    if (o_ld !== 32'h55AA_33CC || o_lv !== 1 || o_stalls !== 2 || o_fault !== 1'b0 ||
        o_addr !== 32'h0000_0604) begin
      fails++;
      $display("FAIL post_reset_lw: got ld=%h lv=%0d stalls=%0d fault=%b addr=%h, want 55aa33cc 1 2 0 00000604",
               o_ld, o_lv, o_stalls, o_fault, o_addr);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_stores();
    test_loads();
    test_access_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
